// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI4-Lite responder exposing a bank of 32-bit control/status registers
//
// Purpose: terminates the AXI4-Lite register-access path. Read-write registers
// drive ctrl_regs to fabric logic; read-only registers return status_in slices.
// AW, W and AR are accepted independently; one write and one read may be in
// flight at the same time and never stall each other.
//
// Ports:
//   axilite_clk, axilite_rst   clock, synchronous active-high reset
//   s_axil_aw*/w*/b*           write address, write data, write response channels
//   s_axil_ar*/r*              read address, read data channels
//   ctrl_regs                  flattened register contents, reg i at [32*i+:32] (RO regs read 0)
//   status_in                  flattened status, only read-only slices are used
//   wr_pulse                   one-cycle pulse per register on a successful write commit
//   rd_pulse                   one-cycle pulse per register on completion of a read

module axil_reg_slave #(
  parameter int                  ADDR_W   = 12,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = 16'h0003,
  parameter logic [31:0]         RST_VAL  = 32'h0000_0000
) (
  input  logic                    axilite_clk,
  input  logic                    axilite_rst,
  input  logic [ADDR_W-1:0]       s_axil_awaddr,
  input  logic [2:0]              s_axil_awprot,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [31:0]             s_axil_wdata,
  input  logic [3:0]              s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_W-1:0]       s_axil_araddr,
  input  logic [2:0]              s_axil_arprot,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [31:0]             s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [NUM_REGS*32-1:0]  ctrl_regs,
  input  logic [NUM_REGS*32-1:0]  status_in,
  output logic [NUM_REGS-1:0]     wr_pulse,
  output logic [NUM_REGS-1:0]     rd_pulse
);

  localparam int IDX_W = ADDR_W - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_COLLECT = 2'd1,
    WR_RESP    = 2'd2
  } wr_state_e;

  // One-hot register select; all zero when the index is beyond the bank.
  function automatic logic [NUM_REGS-1:0] decode(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] dec;
    dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dec[i] = (idx == IDX_W'(i));
    end
    return dec;
  endfunction

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  // ---------------------------------------------------------------------------
  // Write path state
  // ---------------------------------------------------------------------------
  wr_state_e             wr_state_q, wr_state_d;
  logic                  awready_q, awready_d;
  logic                  aw_held_q, aw_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  wready_q, wready_d;
  logic                  w_held_q, w_held_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [31:0]           regs_q [NUM_REGS];
  logic [31:0]           regs_d [NUM_REGS];

  logic                  aw_hs, w_hs;
  logic                  bvalid;
  logic                  commit;
  logic [NUM_REGS-1:0]   wsel;
  logic                  w_in_range, w_is_ro;

  assign aw_hs = s_axil_awvalid && awready_q;
  assign w_hs  = s_axil_wvalid && wready_q;

  // Write FSM: state register
  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      wr_state_q <= WR_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  // Write FSM: next state
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE:    if (aw_hs || w_hs)         wr_state_d = WR_COLLECT;
      WR_COLLECT: if (aw_held_q && w_held_q) wr_state_d = WR_RESP;
      WR_RESP:    if (s_axil_bready)         wr_state_d = WR_IDLE;
      default:                               wr_state_d = WR_IDLE;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    bvalid = 1'b0;
    commit = 1'b0;
    case (wr_state_q)
      WR_COLLECT: commit = aw_held_q && w_held_q;
      WR_RESP:    bvalid = 1'b1;
      default: ;
    endcase
  end

  // AW/W acceptance. Ready is a single-cycle registered pulse, so each channel
  // takes at most one beat until the pending write has been answered.
  always_comb begin
    awready_d = s_axil_awvalid && !aw_held_q && !bvalid && !awready_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axil_awaddr[ADDR_W-1:2];
    end
    if (commit) begin
      aw_held_d = 1'b0;
    end

    wready_d = s_axil_wvalid && !w_held_q && !bvalid && !wready_q;
    w_held_d = w_held_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end
    if (commit) begin
      w_held_d = 1'b0;
    end
  end

  assign wsel       = decode(aw_idx_q);
  assign w_in_range = |wsel;
  assign w_is_ro    = |(wsel & RO_MASK);

  // Commit: byte-merge into the target register and choose the response.
  always_comb begin
    regs_d     = regs_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    if (commit) begin
      if (!w_in_range) begin
        bresp_d = RESP_DECERR;
      end else if (w_is_ro) begin
        bresp_d = RESP_SLVERR;
      end else begin
        bresp_d    = RESP_OKAY;
        wr_pulse_d = wsel;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wsel[i]) begin
            for (int k = 0; k < 4; k++) begin
              if (wstrb_q[k]) begin
                regs_d[i][8*k +: 8] = wdata_q[8*k +: 8];
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      awready_q  <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      wready_q   <= 1'b0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RST_VAL;
      end
    end else begin
      awready_q  <= awready_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      wready_q   <= wready_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic                  arready_q, arready_d;
  logic                  ar_pend_q, ar_pend_d;
  logic [IDX_W-1:0]      ar_idx_q, ar_idx_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [NUM_REGS-1:0]   rd_sel_q, rd_sel_d;
  logic [NUM_REGS-1:0]   rd_pulse_q, rd_pulse_d;

  logic                  ar_hs, r_hs;
  logic [NUM_REGS-1:0]   rsel;
  logic [31:0]           rd_val;

  assign ar_hs = s_axil_arvalid && arready_q;
  assign r_hs  = rvalid_q && s_axil_rready;
  assign rsel  = decode(ar_idx_q);

  // Read mux reads regs_q, so a read landing on a commit edge sees the old value.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rsel[i]) begin
        rd_val = RO_MASK[i] ? status_in[32*i +: 32] : regs_q[i];
      end
    end
  end

  // ar_pend covers the cycle between the AR handshake and rvalid rising, so a
  // second AR cannot slip in before the first response is visible.
  always_comb begin
    arready_d  = s_axil_arvalid && !rvalid_q && !arready_q && !ar_pend_q;
    ar_pend_d  = ar_pend_q;
    ar_idx_d   = ar_idx_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_sel_d   = rd_sel_q;
    rd_pulse_d = r_hs ? rd_sel_q : '0;

    if (ar_hs) begin
      ar_pend_d = 1'b1;
      ar_idx_d  = s_axil_araddr[ADDR_W-1:2];
    end

    if (ar_pend_q) begin
      ar_pend_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = rd_val;
      rresp_d   = (|rsel) ? RESP_OKAY : RESP_DECERR;
      rd_sel_d  = rsel;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      arready_q  <= 1'b0;
      ar_pend_q  <= 1'b0;
      ar_idx_q   <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_sel_q   <= '0;
      rd_pulse_q <= '0;
    end else begin
      arready_q  <= arready_d;
      ar_pend_q  <= ar_pend_d;
      ar_idx_q   <= ar_idx_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_sel_q   <= rd_sel_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_regs = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      ctrl_regs[32*i +: 32] = RO_MASK[i] ? 32'h0 : regs_q[i];
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign wr_pulse       = wr_pulse_q;
  assign rd_pulse       = rd_pulse_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb/tb_axil_reg_slave.sv - self-checking bench for axil_reg_slave

module tb_axil_reg_slave;

  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0003;

  logic            axilite_clk = 1'b0;
  logic            axilite_rst = 1'b1;
  logic [11:0]     s_axil_awaddr = '0;
  logic [2:0]      s_axil_awprot = '0;
  logic            s_axil_awvalid = 1'b0;
  logic            s_axil_awready;
  logic [31:0]     s_axil_wdata = '0;
  logic [3:0]      s_axil_wstrb = '0;
  logic            s_axil_wvalid = 1'b0;
  logic            s_axil_wready;
  logic [1:0]      s_axil_bresp;
  logic            s_axil_bvalid;
  logic            s_axil_bready = 1'b0;
  logic [11:0]     s_axil_araddr = '0;
  logic [2:0]      s_axil_arprot = '0;
  logic            s_axil_arvalid = 1'b0;
  logic            s_axil_arready;
  logic [31:0]     s_axil_rdata;
  logic [1:0]      s_axil_rresp;
  logic            s_axil_rvalid;
  logic            s_axil_rready = 1'b0;
  logic [NR*32-1:0] ctrl_regs;
  logic [NR*32-1:0] status_in;
  logic [NR-1:0]   wr_pulse;
  logic [NR-1:0]   rd_pulse;

  logic [31:0] status [NR];
  logic [31:0] m_regs [NR];

  int checks = 0;
  int failures = 0;

  // results of the last transaction task
  logic [1:0]    r_resp;
  logic [31:0]   r_data;
  logic [NR-1:0] r_pulse;
  int            r_pcyc;
  int            r_rises;
  bit            r_ok;
  bit            r_tmo;

  always #5 axilite_clk = ~axilite_clk;

  always_comb begin
    for (int i = 0; i < NR; i++) status_in[32*i +: 32] = status[i];
  end

  axil_reg_slave dut (
    .axilite_clk(axilite_clk), .axilite_rst(axilite_rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .ctrl_regs(ctrl_regs), .status_in(status_in),
    .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_ctrl(input string name);
    logic [NR*32-1:0] exp;
    for (int i = 0; i < NR; i++) exp[32*i +: 32] = RO[i] ? 32'h0 : m_regs[i];
    checks++;
    if (ctrl_regs !== exp) begin
      failures++;
      $display("FAIL %s ctrl_regs actual=%h expected=%h", name, ctrl_regs, exp);
    end
  endtask

  // ---- reference model: derived from the register map rules ----
  function automatic int idx_of(input logic [11:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [11:0] a);
    int idx = idx_of(a);
    if (idx >= NR) return 2'b11;
    if (RO[idx]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [11:0] a);
    int idx = idx_of(a);
    if (idx >= NR) return 32'h0;
    if (RO[idx]) return status[idx];
    return m_regs[idx];
  endfunction

  function automatic logic [NR-1:0] one_hot(input logic [11:0] a);
    int idx = idx_of(a);
    logic [NR-1:0] v = '0;
    if (idx < NR) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = idx_of(a);
    if (exp_bresp(a) == 2'b00)
      for (int k = 0; k < 4; k++) if (s[k]) m_regs[idx][8*k +: 8] = d[8*k +: 8];
  endtask

  // ---- bus transaction tasks; probe keeps a second AW/W (or AR) pending while the response waits ----
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly, input bit probe);
    bit aw_done = 0, w_done = 0, b_done = 0, aw_hs = 0, w_hs = 0, have = 0, prev_b = 0;
    int cyc = 0;
    r_pulse = '0; r_pcyc = 0; r_rises = 0; r_ok = 1; r_resp = 2'bxx;
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    while (!b_done && cyc < 100) begin
      @(negedge axilite_clk);
      if (aw_hs) begin s_axil_awvalid = 0; aw_done = 1; aw_hs = 0; end
      if (w_hs)  begin s_axil_wvalid = 0;  w_done = 1;  w_hs = 0;  end
      if (wr_pulse != 0) begin r_pulse |= wr_pulse; r_pcyc++; end
      if (s_axil_bvalid && !prev_b) r_rises++;
      prev_b = s_axil_bvalid;
      if (s_axil_bvalid) begin
        if (!have) begin r_resp = s_axil_bresp; have = 1; end
        else if (s_axil_bresp !== r_resp) r_ok = 0;
        if (s_axil_awready || s_axil_wready) r_ok = 0;
      end
      s_axil_bready = (cyc >= b_dly);
      if (s_axil_bvalid && s_axil_bready) b_done = 1;
      if (aw_done && w_done) begin
        s_axil_awvalid = probe && s_axil_bvalid && !s_axil_bready;
        s_axil_wvalid  = s_axil_awvalid;
      end
      if (!aw_done && cyc >= aw_dly) s_axil_awvalid = 1;
      if (!w_done && cyc >= w_dly) s_axil_wvalid = 1;
      aw_hs = !aw_done && s_axil_awvalid && s_axil_awready;
      w_hs  = !w_done && s_axil_wvalid && s_axil_wready;
      cyc++;
    end
    r_tmo = !b_done;
    repeat (2) begin
      @(negedge axilite_clk);
      s_axil_bready = 0; s_axil_awvalid = 0; s_axil_wvalid = 0;
      if (wr_pulse != 0) begin r_pulse |= wr_pulse; r_pcyc++; end
      if (s_axil_bvalid) r_ok = 0;
    end
  endtask

  task automatic axi_read(input logic [11:0] a, input int ar_dly, input int r_dly, input bit probe);
    bit ar_done = 0, r_done = 0, ar_hs = 0, have = 0;
    int cyc = 0;
    r_pulse = '0; r_pcyc = 0; r_ok = 1; r_resp = 2'bxx; r_data = 'x;
    s_axil_araddr = a;
    while (!r_done && cyc < 100) begin
      @(negedge axilite_clk);
      if (ar_hs) begin s_axil_arvalid = 0; ar_done = 1; ar_hs = 0; end
      if (rd_pulse != 0) begin r_pulse |= rd_pulse; r_pcyc++; end
      if (s_axil_rvalid) begin
        if (!have) begin r_data = s_axil_rdata; r_resp = s_axil_rresp; have = 1; end
        else if (s_axil_rdata !== r_data || s_axil_rresp !== r_resp) r_ok = 0;
        if (s_axil_arready) r_ok = 0;
      end
      s_axil_rready = (cyc >= r_dly);
      if (s_axil_rvalid && s_axil_rready) r_done = 1;
      if (ar_done) s_axil_arvalid = probe && s_axil_rvalid && !s_axil_rready;
      else if (cyc >= ar_dly) s_axil_arvalid = 1;
      ar_hs = !ar_done && s_axil_arvalid && s_axil_arready;
      cyc++;
    end
    r_tmo = !r_done;
    repeat (2) begin
      @(negedge axilite_clk);
      s_axil_rready = 0; s_axil_arvalid = 0;
      if (rd_pulse != 0) begin r_pulse |= rd_pulse; r_pcyc++; end
      if (s_axil_rvalid) r_ok = 0;
    end
  endtask

  task automatic do_write(input string tag, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_resp, input int awd, input int wd, input int bd, input bit probe);
    axi_write(a, d, s, awd, wd, bd, probe);
    chk({tag, "_timeout"}, r_tmo, 0);
    chk({tag, "_bresp"}, r_resp, exp_resp);
    chk({tag, "_protocol"}, r_ok, 1);
    chk({tag, "_commits"}, r_rises, 1);
    chk({tag, "_wr_pulse"}, r_pulse, exp_resp == 2'b00 ? one_hot(a) : '0);
    chk({tag, "_wr_pulse_cycles"}, r_pcyc, exp_resp == 2'b00 ? 1 : 0);
    model_write(a, d, s);
    chk_ctrl({tag, "_ctrl"});
  endtask

  task automatic do_read(input string tag, input logic [11:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int ard, input int rd, input bit probe);
    axi_read(a, ard, rd, probe);
    chk({tag, "_timeout"}, r_tmo, 0);
    chk({tag, "_rdata"}, r_data, exp_data);
    chk({tag, "_rresp"}, r_resp, exp_resp);
    chk({tag, "_protocol"}, r_ok, 1);
    chk({tag, "_rd_pulse"}, r_pulse, one_hot(a));
    chk({tag, "_rd_pulse_cycles"}, r_pcyc, idx_of(a) < NR ? 1 : 0);
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [13];

  initial begin
    bit seen_b;
    for (int i = 0; i < NR; i++) begin status[i] = $urandom; m_regs[i] = 32'h0; end
    status[0] = 32'h5A5A_0001;
    status[1] = 32'h0000_CAFE;

    tbl[0]  = '{0, 12'h008, 32'h0,         4'h0,    2'b00, 32'h0};
    tbl[1]  = '{1, 12'h008, 32'hDEADBEEF,  4'hF,    2'b00, 32'h0};
    tbl[2]  = '{0, 12'h008, 32'h0,         4'h0,    2'b00, 32'hDEADBEEF};
    tbl[3]  = '{1, 12'h00C, 32'h11223344,  4'hF,    2'b00, 32'h0};
    tbl[4]  = '{1, 12'h00C, 32'hAABBCCDD,  4'b0101, 2'b00, 32'h0};
    tbl[5]  = '{0, 12'h00C, 32'h0,         4'h0,    2'b00, 32'h11BB33DD};
    tbl[6]  = '{1, 12'h004, 32'h12345678,  4'hF,    2'b10, 32'h0};
    tbl[7]  = '{0, 12'h004, 32'h0,         4'h0,    2'b00, 32'h0000CAFE};
    tbl[8]  = '{1, 12'h100, 32'h87654321,  4'hF,    2'b11, 32'h0};
    tbl[9]  = '{0, 12'h100, 32'h0,         4'h0,    2'b11, 32'h0};
    tbl[10] = '{1, 12'h03C, 32'hFFFFFFFF,  4'h0,    2'b00, 32'h0};
    tbl[11] = '{0, 12'h03F, 32'h0,         4'h0,    2'b00, 32'h0};
    tbl[12] = '{0, 12'h000, 32'h0,         4'h0,    2'b00, 32'h5A5A0001};

    // reset
    repeat (2) @(negedge axilite_clk);
    chk("rst_ready_valid", {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid}, 0);
    chk("rst_resp_rdata", {s_axil_bresp, s_axil_rresp, s_axil_rdata}, 0);
    chk("rst_pulses", {wr_pulse, rd_pulse}, 0);
    chk_ctrl("rst");
    axilite_rst = 0;
    @(negedge axilite_clk);

    // directed table
    foreach (tbl[i]) begin
      if (tbl[i].wr)
        do_write($sformatf("tbl%0d_wr", i), tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp, 0, 0, 0, 0);
      else
        do_read($sformatf("tbl%0d_rd", i), tbl[i].addr, tbl[i].rdata, tbl[i].resp, 0, 0, 0);
    end

    // latency: AW and W together at cycle n
    @(negedge axilite_clk);
    s_axil_awaddr = 12'h014; s_axil_wdata = 32'h13579BDF; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1; s_axil_wvalid = 1;
    @(negedge axilite_clk);
    chk("lat_wr_n1_ready", {s_axil_awready, s_axil_wready, s_axil_bvalid}, 3'b110);
    @(negedge axilite_clk);
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    chk("lat_wr_n2_bvalid", s_axil_bvalid, 0);
    @(negedge axilite_clk);
    chk("lat_wr_n3_bvalid", {s_axil_bvalid, s_axil_bresp}, 3'b100);
    chk("lat_wr_n3_reg", ctrl_regs[32*5 +: 32], 32'h13579BDF);
    chk("lat_wr_n3_pulse", wr_pulse, 16'h0020);
    s_axil_bready = 1;
    @(negedge axilite_clk);
    s_axil_bready = 0;
    chk("lat_wr_done", s_axil_bvalid, 0);
    model_write(12'h014, 32'h13579BDF, 4'hF);

    // latency: AR at cycle n
    s_axil_araddr = 12'h014; s_axil_arvalid = 1;
    @(negedge axilite_clk);
    chk("lat_rd_n1_arready", {s_axil_arready, s_axil_rvalid}, 2'b10);
    @(negedge axilite_clk);
    s_axil_arvalid = 0;
    chk("lat_rd_n2_rvalid", s_axil_rvalid, 0);
    @(negedge axilite_clk);
    chk("lat_rd_n3_rvalid", {s_axil_rvalid, s_axil_rresp}, 3'b100);
    chk("lat_rd_n3_rdata", s_axil_rdata, 32'h13579BDF);
    s_axil_rready = 1;
    @(negedge axilite_clk);
    s_axil_rready = 0;
    chk("lat_rd_pulse", rd_pulse, 16'h0020);

    // ordering and backpressure: W 5 cycles ahead of AW, response held 4 cycles
    do_write("order_w_first", 12'h020, 32'hC0FFEE01, 4'hF, 2'b00, 5, 0, 12, 1);
    do_write("order_aw_first", 12'h024, 32'h0BADF00D, 4'b1010, 2'b00, 0, 6, 13, 1);
    do_read("bp_read", 12'h020, m_regs[8], 2'b00, 0, 7, 1);

    // randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      int sel;
      logic [9:0] idx;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0] s;
      status[0] = $urandom; status[1] = $urandom;
      sel = $urandom_range(0, 19);
      idx = (sel < 18) ? 10'(sel) : 10'(64 + sel);
      a = {idx, 2'($urandom_range(0, 3))};
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        do_write($sformatf("rnd%0d_wr", it), a, d, s, exp_bresp(a),
                 $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
      else
        do_read($sformatf("rnd%0d_rd", it), a, exp_rdata(a), idx_of(a) < NR ? 2'b00 : 2'b11,
                $urandom_range(0, 4), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    // reset between AW and W: the orphaned address must never produce a response
    s_axil_awaddr = 12'h018; s_axil_awvalid = 1;
    for (int c = 0; c < 10 && !s_axil_awready; c++) @(negedge axilite_clk);
    chk("midrst_awready", s_axil_awready, 1);
    @(negedge axilite_clk);
    s_axil_awvalid = 0;
    axilite_rst = 1;
    @(negedge axilite_clk);
    axilite_rst = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
    seen_b = 0;
    repeat (10) begin
      @(negedge axilite_clk);
      if (s_axil_bvalid) seen_b = 1;
    end
    chk("midrst_no_bvalid", seen_b, 0);
    chk_ctrl("midrst");
    do_write("post_rst_wr", 12'h00C, 32'h5, 4'hF, 2'b00, 0, 0, 0, 0);
    do_read("post_rst_rd", 12'h00C, 32'h5, 2'b00, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
